// File: rtl/mips_dmem_mmio.sv
// Data memory stage for the single-cycle MIPS core: word RAM plus an MMIO page
// (UART TX, cycle counter, LEDs). Define UART_PARITY_EN to add an even-parity bit.
module mips_dmem_mmio #(
    parameter int unsigned DEPTH_WORDS  = 64,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        uart_tx,
    output logic [7:0]  leds
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          page_hit;
    logic          sel_tx, sel_cyc, sel_led;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bitidx, bitidx_n;
    logic [7:0]    txbyte, txbyte_n;
    logic          tx_q, tx_n;
    logic          busy;
    logic          tick;
    logic          tx_start;

    logic [31:0]   cyccnt;
    logic [7:0]    leds_q;

    // Byte-lane bits are don't-care for word accesses.
    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[1:0];

    assign ram_idx  = addr[AW+1:2];
    assign ram_hit  = (addr[31:AW+2] == '0);
    assign page_hit = (addr[31:4] == 28'hFFFFFF0);
    assign sel_tx   = page_hit && (addr[3:2] == 2'd0);
    assign sel_cyc  = page_hit && (addr[3:2] == 2'd2);
    assign sel_led  = page_hit && (addr[3:2] == 2'd3);

    assign busy     = (state != S_IDLE);
    assign tick     = (baud == BAUD_LAST);
    assign tx_start = memwrite && sel_tx && !busy;

    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) begin
            mem[ram_idx] <= writedata;
        end
    end

    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = mem[ram_idx];
        end else if (page_hit) begin
            case (addr[3:2])
                2'd1:    readdata = {31'b0, busy};
                2'd2:    readdata = cyccnt;
                2'd3:    readdata = {24'b0, leds_q};
                default: readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyccnt <= '0;
            leds_q <= '0;
        end else begin
            cyccnt <= (memwrite && sel_cyc) ? writedata : cyccnt + 32'd1;
            if (memwrite && sel_led) begin
                leds_q <= writedata[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            baud   <= '0;
            bitidx <= '0;
            txbyte <= '0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitidx <= bitidx_n;
            txbyte <= txbyte_n;
            tx_q   <= tx_n;
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud + BW'(1);
        bitidx_n = bitidx;
        txbyte_n = txbyte;
        case (state)
            S_IDLE: begin
                baud_n   = '0;
                bitidx_n = '0;
                if (tx_start) begin
                    state_n  = S_START;
                    txbyte_n = writedata[7:0];
                end
            end
            S_START: begin
                if (tick) begin
                    baud_n  = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_n = '0;
                    if (bitidx == 3'd7) begin
                        bitidx_n = '0;
`ifdef UART_PARITY_EN
                        state_n  = S_PARITY;
`else
                        state_n  = S_STOP;
`endif
                    end else begin
                        bitidx_n = bitidx + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                baud_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // The line level is derived from the next state so the register holds
    // exactly the bit that belongs to the state being entered.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = txbyte_n[bitidx_n];
`ifdef UART_PARITY_EN
            S_PARITY: tx_n = ^txbyte_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    assign uart_tx = tx_q;
    assign leds    = leds_q;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed self-checking bench for mips_dmem_mmio (DEPTH_WORDS=64, CLKS_PER_BIT=4).
module tb_mips_dmem_mmio;

    localparam int unsigned DEPTH = 64;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
`endif
    localparam int FRAME = CPB * NB;

    localparam logic [31:0] A_TX  = 32'hFFFFFF00;
    localparam logic [31:0] A_ST  = 32'hFFFFFF04;
    localparam logic [31:0] A_CYC = 32'hFFFFFF08;
    localparam logic [31:0] A_LED = 32'hFFFFFF0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        uart_tx;
    logic [7:0]  leds;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] model [DEPTH];

    mips_dmem_mmio #(
        .DEPTH_WORDS (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .addr     (addr),
        .writedata(writedata),
        .readdata (readdata),
        .uart_tx  (uart_tx),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite  = we;
        addr      = a;
        writedata = d;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int idx;
        if (c == 0) return 1'b1;
        idx = (c - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Cycle 0 issues the TXDATA write; returns positioned at cycle FRAME+1.
    task automatic tx_frame(input logic [7:0] b, input int drop_at);
        for (int c = 0; c <= FRAME; c++) begin
            if (c == 0)            drive(1'b1, A_TX, {24'h0, b});
            else if (c == drop_at) drive(1'b1, A_TX, 32'h000000A3);
            else                   drive(1'b0, A_ST, 32'h0);
            @(negedge clk);
            chk($sformatf("tx_%02h_c%0d", b, c), {31'b0, uart_tx}, {31'b0, exp_tx(b, c)});
            chk($sformatf("rd_%02h_c%0d", b, c), readdata,
                (addr == A_ST) ? {31'b0, (c >= 1)} : 32'h0);
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, A_CYC, 32'h0);
        step();
        step();
        @(negedge clk);
        chk("rst_tx", {31'b0, uart_tx}, 32'h1);
        chk("rst_leds", {24'b0, leds}, 32'h0);
        reset = 1'b0;
        step();

        // RAM preload with a distinct pattern per word
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, A_CYC, 32'h0);
        @(negedge clk);
        chk("rst_cyc0", readdata, 32'h0);
        step();
        @(negedge clk);
        chk("cyc_inc", readdata, 32'h1);
        step();
        for (int i = 0; i < int'(DEPTH); i++) begin
            model[i] = 32'h10000000 + 32'(i) * 32'h01010101;
            drive(1'b1, 32'(i * 4), model[i]);
            step();
        end

        // RAM write with read-during-write, then aliased reads
        drive(1'b1, 32'h10, 32'h12345678);
        @(negedge clk);
        chk("ram_rdw_old", readdata, model[4]);
        step();
        model[4] = 32'h12345678;
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("ram_rd_10", readdata, 32'h12345678);
        step();
        drive(1'b0, 32'h13, 32'h0);
        @(negedge clk);
        chk("ram_rd_13", readdata, 32'h12345678);
        step();
        drive(1'b0, 32'h14, 32'h0);
        @(negedge clk);
        chk("ram_rd_14", readdata, model[5]);
        step();

        // CYCCNT load and wrap
        drive(1'b1, A_CYC, 32'hFFFFFFFE);
        step();
        drive(1'b0, A_CYC, 32'h0);
        @(negedge clk);
        chk("cyc_load", readdata, 32'hFFFFFFFE);
        step();
        @(negedge clk);
        chk("cyc_max", readdata, 32'hFFFFFFFF);
        step();
        @(negedge clk);
        chk("cyc_wrap", readdata, 32'h00000000);
        step();

        // LED register takes only the low byte
        drive(1'b1, A_LED, 32'h12345A5A);
        step();
        drive(1'b0, A_LED, 32'h0);
        @(negedge clk);
        chk("led_rd", readdata, 32'h0000005A);
        chk("led_port", {24'b0, leds}, 32'h5A);
        step();

        // Plain frame, frame with a dropped write, then back-to-back frame
        tx_frame(8'h55, -1);
        tx_frame(8'h55, 10);
        tx_frame(8'h07, -1);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, A_ST, 32'h0);
            @(negedge clk);
            chk("idle_tx", {31'b0, uart_tx}, 32'h1);
            chk("idle_busy", readdata, 32'h0);
            step();
        end

        // Reset in the middle of a frame
        drive(1'b1, A_TX, 32'h00000055);
        step();
        for (int c = 1; c < 20; c++) begin
            drive(1'b0, A_ST, 32'h0);
            step();
        end
        @(negedge clk);
        chk("mid_tx_c19", {31'b0, uart_tx}, {31'b0, exp_tx(8'h55, 19)});
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, A_CYC, 32'h0);
        @(negedge clk);
        chk("mrst_tx", {31'b0, uart_tx}, 32'h1);
        chk("mrst_leds", {24'b0, leds}, 32'h0);
        chk("mrst_cyc", readdata, 32'h0);
        step();
        drive(1'b0, A_ST, 32'h0);
        @(negedge clk);
        chk("mrst_busy", readdata, 32'h0);
        chk("mrst_tx2", {31'b0, uart_tx}, 32'h1);
        step();
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("mrst_ram", readdata, 32'h12345678);
        step();

        // Unmapped accesses
        drive(1'b1, 32'h100, 32'hDEADBEEF);
        step();
        drive(1'b1, 32'hFFFFFF10, 32'hDEADBEEF);
        step();
        drive(1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("unm_rd_100", readdata, 32'h0);
        step();
        drive(1'b0, 32'hFFFFFF10, 32'h0);
        @(negedge clk);
        chk("unm_rd_f10", readdata, 32'h0);
        chk("unm_leds", {24'b0, leds}, 32'h0);
        step();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 32'(i * 4), 32'h0);
            @(negedge clk);
            chk($sformatf("ram_w%0d", i), readdata, model[i]);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
